// File: rtl/stack8_arbiter.sv
// Round-robin two-port arbiter and controller for an 8-entry LIFO stack.
// One push/pop is served per cycle; results return through a registered acknowledge.
module stack8_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             a_req,
   input  logic             a_op,
   input  logic [WIDTH-1:0] a_din,
   output logic             a_gnt,
   output logic             a_ack,
   output logic             a_err,
   output logic [WIDTH-1:0] a_dout,
   input  logic             b_req,
   input  logic             b_op,
   input  logic [WIDTH-1:0] b_din,
   output logic             b_gnt,
   output logic             b_ack,
   output logic             b_err,
   output logic [WIDTH-1:0] b_dout,
   output logic [0:7]       occ,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [8];
   logic [0:7]       occ_q, occ_d;
   logic             last_q;  // 0: A was last granted, 1: B was last granted
   logic             a_ack_q, a_err_q, b_ack_q, b_err_q;
   logic [WIDTH-1:0] a_dout_q, b_dout_q;

   logic             go, sel_op, wr_en, op_err;
   logic [WIDTH-1:0] sel_din, op_dout;
   logic [2:0]       wr_idx, rd_idx;

   // Push slot counts ones below the full bit; pop slot counts ones above the empty bit.
   // Each equals cnt or cnt-1 exactly when the respective operation is legal.
   always_comb begin
      wr_idx = '0;
      rd_idx = '0;
      for (int i = 1; i < 8; i++) wr_idx = wr_idx + {2'b00, occ_q[i]};
      for (int i = 0; i < 7; i++) rd_idx = rd_idx + {2'b00, occ_q[i]};
   end

   always_comb begin
      a_gnt   = a_req & (~b_req | last_q);
      b_gnt   = b_req & ~a_gnt;
      go      = a_gnt | b_gnt;
      sel_op  = a_gnt ? a_op : b_op;
      sel_din = a_gnt ? a_din : b_din;
      occ_d   = occ_q;
      wr_en   = 1'b0;
      op_err  = 1'b0;
      op_dout = '0;
      if (go) begin
         if (sel_op) begin
            if (occ_q[0]) begin
               op_err = 1'b1;
            end else begin
               wr_en = 1'b1;
               occ_d = {occ_q[1:7], 1'b1};
            end
         end else begin
            if (!occ_q[7]) begin
               op_err = 1'b1;
            end else begin
               op_dout = mem_q[rd_idx];
               occ_d   = {1'b0, occ_q[0:6]};
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         occ_q    <= '0;
         last_q   <= 1'b1;
         a_ack_q  <= 1'b0;
         a_err_q  <= 1'b0;
         a_dout_q <= '0;
         b_ack_q  <= 1'b0;
         b_err_q  <= 1'b0;
         b_dout_q <= '0;
      end else begin
         occ_q    <= occ_d;
         if (go) last_q <= b_gnt;
         a_ack_q  <= a_gnt;
         a_err_q  <= a_gnt & op_err;
         a_dout_q <= a_gnt ? op_dout : '0;
         b_ack_q  <= b_gnt;
         b_err_q  <= b_gnt & op_err;
         b_dout_q <= b_gnt ? op_dout : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wr_en) mem_q[wr_idx] <= sel_din;
   end

   assign a_ack  = a_ack_q;
   assign a_err  = a_err_q;
   assign a_dout = a_dout_q;
   assign b_ack  = b_ack_q;
   assign b_err  = b_err_q;
   assign b_dout = b_dout_q;
   assign occ    = occ_q;
   assign full   = occ_q[0];
   assign empty  = ~occ_q[7];

endmodule

// File: tb/tb_stack8_arbiter.sv
// Directed bench for stack8_arbiter: a small stack model predicts grants and
// queues the expected acknowledge, which is compared the cycle after the grant.
module tb_stack8_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        a_req, a_op, b_req, b_op;
   logic [31:0] a_din, b_din;
   logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
   logic [31:0] a_dout, b_dout;
   logic [0:7]  occ;
   logic        full, empty;

   stack8_arbiter #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .a_req (a_req),
      .a_op  (a_op),
      .a_din (a_din),
      .a_gnt (a_gnt),
      .a_ack (a_ack),
      .a_err (a_err),
      .a_dout(a_dout),
      .b_req (b_req),
      .b_op  (b_op),
      .b_din (b_din),
      .b_gnt (b_gnt),
      .b_ack (b_ack),
      .b_err (b_err),
      .b_dout(b_dout),
      .occ   (occ),
      .full  (full),
      .empty (empty)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        a_ack, a_err, b_ack, b_err;
      logic [31:0] a_dout, b_dout;
      logic [7:0]  occ;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mst[8];
   int          m_cnt = 0;
   logic        m_last = 1'b1;
   logic        dut_ga, dut_gb;
   logic [3:0]  gseq;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check grants and predict at negedge, check acknowledge after posedge.
   task automatic tick();
      logic  ga, gb, op, err;
      logic [31:0] din, dout;
      exp_t  e, got;
      @(negedge clock);
      ga = a_req && (!b_req || m_last);
      gb = b_req && !ga;
      dut_ga = a_gnt;
      dut_gb = b_gnt;
      chk("a_gnt", a_gnt, ga);
      chk("b_gnt", b_gnt, gb);
      e = '{default: '0};
      if (reset) begin
         m_cnt  = 0;
         m_last = 1'b1;
      end else if (ga || gb) begin
         op   = ga ? a_op : b_op;
         din  = ga ? a_din : b_din;
         err  = 1'b0;
         dout = '0;
         if (op) begin
            if (m_cnt == 8) err = 1'b1;
            else begin
               mst[m_cnt] = din;
               m_cnt++;
            end
         end else begin
            if (m_cnt == 0) err = 1'b1;
            else begin
               m_cnt--;
               dout = mst[m_cnt];
            end
         end
         if (ga) begin
            e.a_ack = 1'b1; e.a_err = err; e.a_dout = dout;
         end else begin
            e.b_ack = 1'b1; e.b_err = err; e.b_dout = dout;
         end
         m_last = gb;
      end
      e.occ = 8'((1 << m_cnt) - 1);
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         chk("a_ack", a_ack, got.a_ack);
         chk("a_err", a_err, got.a_err);
         chk("a_dout", a_dout, got.a_dout);
         chk("b_ack", b_ack, got.b_ack);
         chk("b_err", b_err, got.b_err);
         chk("b_dout", b_dout, got.b_dout);
         chk("occ", occ, got.occ);
         chk("full", full, got.occ == 8'hFF);
         chk("empty", empty, got.occ == 8'h00);
      end
   endtask

   initial begin
      int na, nb;
      reset = 1'b1;
      a_req = 1'b0; a_op = 1'b0; a_din = '0;
      b_req = 1'b0; b_op = 1'b0; b_din = '0;
      #1;
      tick();
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // A: three pushes then three pops
      a_req = 1'b1; a_op = 1'b1;
      a_din = 32'h11; tick();
      a_din = 32'h22; tick();
      a_din = 32'h33; tick();
      a_op = 1'b0;
      repeat (3) tick();
      a_req = 1'b0;

      // B pops on empty: error with zero data, and B becomes last
      b_req = 1'b1; b_op = 1'b0; tick();
      b_req = 1'b0; tick();

      // Contention: grants alternate starting with A
      a_req = 1'b1; a_op = 1'b1; b_req = 1'b1; b_op = 1'b1;
      na = 0; nb = 0; gseq = '0;
      repeat (4) begin
         a_din = 32'hA0 + na;
         b_din = 32'hB0 + nb;
         tick();
         gseq = {gseq[2:0], dut_ga};
         if (dut_ga) na++;
         if (dut_gb) nb++;
      end
      chk("alternation", {28'd0, gseq}, 32'h0000000A);
      b_req = 1'b0; a_op = 1'b0;
      repeat (4) tick();
      a_req = 1'b0; tick();

      // Fill to full, overflow, then pop the last value
      a_req = 1'b1; a_op = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_din = 32'h100 + i;
         tick();
      end
      chk("occ_full", occ, 32'hFF);
      chk("full_flag", full, 32'd1);
      a_din = 32'h1FF; tick();
      a_op = 1'b0; tick();
      repeat (7) tick();
      a_op = 1'b1;
      a_din = 32'h55; tick();
      a_din = 32'h66; tick();
      chk("occ_three", occ, 32'h03);

      // Reset coincides with a granted push: no ack, stack cleared, A wins next contention
      reset = 1'b1; a_din = 32'h77; tick();
      reset = 1'b0; a_req = 1'b0; tick();
      a_req = 1'b1; b_req = 1'b1; a_din = 32'h88; b_din = 32'h99; tick();
      chk("post_reset_winner", {31'd0, dut_ga}, 32'd1);
      a_req = 1'b0; b_req = 1'b0; tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
